// File: rtl/eva_axi_pkg.sv
// Shared AXI read-channel constants and encodings for the EVA read arbiter.
package eva_axi_pkg;

  localparam int AXI_ID_W   = 6;
  localparam int AXI_ADDR_W = 64;
  localparam int AXI_DATA_W = 128;
  localparam int AXI_LEN_W  = 6;
  localparam int AXI_SIZE_W = 3;
  localparam int OUTS_W     = 4;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

endpackage

// File: rtl/eva_rr_arb.sv
// Combinational round-robin picker: searches from the slot after ptr,
// wrapping, and returns the first requester as one-hot plus index.
module eva_rr_arb #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int            cand;
  logic [IW-1:0] cand_idx;

  // Walk the N candidates in priority order; the first hit wins.
  always_comb begin
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= N; k++) begin
      cand     = (int'(ptr) + k) % N;
      cand_idx = IW'(cand);
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/eva_axi_rd_arb.sv
// Shares one EVA AXI read port between NUM_M masters: round-robin AR
// arbitration with an index prefix on ARID, RID-prefix R routing, and a
// per-master outstanding-burst limit.
module eva_axi_rd_arb
  import eva_axi_pkg::*;
#(
  parameter int NUM_M    = 4,
  parameter int IDW_M    = 4,
  parameter int MAX_OUTS = 8
) (
  input  logic                     aclk,
  input  logic                     arest_n,
  input  logic [NUM_M-1:0]         s_arvalid,
  output logic [NUM_M-1:0]         s_arready,
  input  logic [NUM_M*IDW_M-1:0]   s_arid,
  input  logic [NUM_M*64-1:0]      s_araddr,
  input  logic [NUM_M*6-1:0]       s_arlen,
  input  logic [NUM_M*3-1:0]       s_arsize,
  input  logic [NUM_M*2-1:0]       s_arburst,
  output logic [NUM_M-1:0]         s_rvalid,
  input  logic [NUM_M-1:0]         s_rready,
  output logic [IDW_M-1:0]         s_rid,
  output logic [AXI_DATA_W-1:0]    s_rdata,
  output logic                     s_rlast,
  output logic [1:0]               s_rresp,
  output logic                     m_arvalid,
  input  logic                     m_arready,
  output logic [AXI_ID_W-1:0]      m_arid,
  output logic [AXI_ADDR_W-1:0]    m_araddr,
  output logic [AXI_LEN_W-1:0]     m_arlen,
  output logic [AXI_SIZE_W-1:0]    m_arsize,
  output logic [1:0]               m_arburst,
  input  logic                     m_rvalid,
  output logic                     m_rready,
  input  logic [AXI_ID_W-1:0]      m_rid,
  input  logic [AXI_DATA_W-1:0]    m_rdata,
  input  logic                     m_rlast,
  input  logic [1:0]               m_rresp,
  output logic                     rid_err
);

  localparam int IW = $clog2(NUM_M);
  localparam logic [IW:0] NUM_M_W = (IW+1)'(NUM_M);
  localparam logic [OUTS_W-1:0] OUTS_LIMIT = OUTS_W'(MAX_OUTS);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]        state_reg;
  logic [IW-1:0]     ptr_reg;
  logic [IW-1:0]     grant_idx_reg;
  logic [NUM_M-1:0]  elig;
  logic [NUM_M-1:0]  pick_oh;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic [NUM_M-1:0]  ar_hs;
  logic [NUM_M-1:0]  r_dec;
  logic [OUTS_W-1:0] outs_cnt [NUM_M];
  logic [IW-1:0]     sel;
  logic              sel_valid;
  logic              r_last_hs;

  eva_rr_arb #(.N(NUM_M), .IW(IW)) u_rr (
    .req   (elig),
    .ptr   (ptr_reg),
    .grant (pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // The slave handshake is offered only while the AR latch is free.
  assign s_arready = (state_reg == ST_IDLE) ? pick_oh : '0;
  assign ar_hs     = s_arvalid & s_arready;

  // R routing: the top ID bits name the master, the rest pass back as RID.
  assign sel       = m_rid[AXI_ID_W-1 -: IW];
  assign sel_valid = ({1'b0, sel} < NUM_M_W);
  assign s_rid     = m_rid[IDW_M-1:0];
  assign s_rdata   = m_rdata;
  assign s_rlast   = m_rlast;
  assign s_rresp   = m_rresp;
  assign r_last_hs = m_rvalid & m_rready & m_rlast;

  // Ready comes from the addressed master; beats for unknown masters are sunk.
  always_comb begin
    m_rready = 1'b1;
    for (int i = 0; i < NUM_M; i++) begin
      if (sel == IW'(i)) m_rready = s_rready[i];
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_M; gi++) begin : g_master
      assign s_rvalid[gi] = m_rvalid & sel_valid & (sel == IW'(gi));
      assign r_dec[gi]    = r_last_hs & sel_valid & (sel == IW'(gi));
      assign elig[gi]     = s_arvalid[gi] & (outs_cnt[gi] != OUTS_LIMIT);

      // Outstanding bursts: up on AR accept, down on the last R beat; a
      // stray rlast after reset cannot wrap the counter below zero.
      always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
          outs_cnt[gi] <= '0;
        end else if (ar_hs[gi] && !(r_dec[gi] && outs_cnt[gi] != '0)) begin
          outs_cnt[gi] <= outs_cnt[gi] + OUTS_W'(1);
        end else if (!ar_hs[gi] && r_dec[gi] && outs_cnt[gi] != '0) begin
          outs_cnt[gi] <= outs_cnt[gi] - OUTS_W'(1);
        end
      end
    end
  endgenerate

  // Sticky flag for any R beat whose prefix addresses no master.
  always_ff @(posedge aclk or negedge arest_n) begin
    if (!arest_n) begin
      rid_err <= 1'b0;
    end else if (m_rvalid && !sel_valid) begin
      rid_err <= 1'b1;
    end
  end

  // AR FSM: accept and latch in IDLE, present to the slave in HOLD.
  always_ff @(posedge aclk or negedge arest_n) begin
    if (!arest_n) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= IW'(NUM_M - 1);
      grant_idx_reg <= '0;
      m_arvalid     <= 1'b0;
      m_arid        <= '0;
      m_araddr      <= '0;
      m_arlen       <= '0;
      m_arsize      <= '0;
      m_arburst     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pick_any) begin
            grant_idx_reg <= pick_idx;
            m_arid        <= {pick_idx, s_arid[pick_idx*IDW_M +: IDW_M]};
            m_araddr      <= s_araddr[pick_idx*64 +: 64];
            m_arlen       <= s_arlen[pick_idx*6 +: 6];
            m_arsize      <= s_arsize[pick_idx*3 +: 3];
            m_arburst     <= s_arburst[pick_idx*2 +: 2];
            m_arvalid     <= 1'b1;
            state_reg     <= ST_HOLD;
          end
        end
        default: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            ptr_reg   <= grant_idx_reg;
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
